// File: rtl/bcd_countdown_if.sv
// Control/preset bundle and registered count outputs of the HH:MM countdown timer.
interface bcd_countdown_if;
  logic       tick;
  logic       load;
  logic [3:0] load_ms_hour;
  logic [3:0] load_ls_hour;
  logic [3:0] load_ms_min;
  logic [3:0] load_ls_min;
  logic       start;
  logic       stop;
  logic [3:0] ms_hour;
  logic [3:0] ls_hour;
  logic [3:0] ms_min;
  logic [3:0] ls_min;
  logic       running;
  logic       expired;
  logic       load_err;

  modport master (
    output tick, load, load_ms_hour, load_ls_hour, load_ms_min, load_ls_min,
           start, stop,
    input  ms_hour, ls_hour, ms_min, ls_min, running, expired, load_err
  );

  modport slave (
    input  tick, load, load_ms_hour, load_ls_hour, load_ms_min, load_ls_min,
           start, stop,
    output ms_hour, ls_hour, ms_min, ls_min, running, expired, load_err
  );
endinterface

// File: rtl/bcd_countdown.sv
// HH:MM BCD countdown timer: preset load with range check, start/stop, minute
// tick decrement with full borrow ripple, optional auto-reload at expiry.
module bcd_countdown #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  bcd_countdown_if.slave   cd_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] mh_q, lh_q, mm_q, lm_q;
  logic [3:0] mh_d, lh_d, mm_d, lm_d;
  logic [3:0] rmh_q, rlh_q, rmm_q, rlm_q;
  logic [3:0] rmh_d, rlh_d, rmm_d, rlm_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       load_err_q, load_err_d;

  logic       load_ok;
  logic       cnt_zero, rld_zero, dec_zero;
  logic       b0, b1, b2;
  logic [3:0] mh_dec, lh_dec, mm_dec, lm_dec;

  // Hours tens may be 2 only when hours units stay within 0..3.
  assign load_ok = (cd_if.load_ls_min  <= 4'd9) &&
                   (cd_if.load_ms_min  <= 4'd5) &&
                   (cd_if.load_ls_hour <= 4'd9) &&
                   (cd_if.load_ms_hour <= 4'd2) &&
                   ((cd_if.load_ms_hour != 4'd2) || (cd_if.load_ls_hour <= 4'd3));

  assign cnt_zero = (mh_q == 4'd0) && (lh_q == 4'd0) && (mm_q == 4'd0) && (lm_q == 4'd0);
  assign rld_zero = (rmh_q == 4'd0) && (rlh_q == 4'd0) && (rmm_q == 4'd0) && (rlm_q == 4'd0);

  // One-minute decrement; each borrow feeds the next digit in the same cycle.
  assign b0     = (lm_q == 4'd0);
  assign lm_dec = b0 ? 4'd9 : lm_q - 4'd1;
  assign b1     = b0 && (mm_q == 4'd0);
  assign mm_dec = b0 ? ((mm_q == 4'd0) ? 4'd5 : mm_q - 4'd1) : mm_q;
  assign b2     = b1 && (lh_q == 4'd0);
  assign lh_dec = b1 ? ((lh_q == 4'd0) ? 4'd9 : lh_q - 4'd1) : lh_q;
  assign mh_dec = (b2 && (mh_q != 4'd0)) ? mh_q - 4'd1 : mh_q;

  assign dec_zero = (mh_dec == 4'd0) && (lh_dec == 4'd0) &&
                    (mm_dec == 4'd0) && (lm_dec == 4'd0);

  always_comb begin
    state_d    = state_q;
    mh_d       = mh_q;
    lh_d       = lh_q;
    mm_d       = mm_q;
    lm_d       = lm_q;
    rmh_d      = rmh_q;
    rlh_d      = rlh_q;
    rmm_d      = rmm_q;
    rlm_d      = rlm_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;

    if (cd_if.load) begin
      if (load_ok) begin
        mh_d    = cd_if.load_ms_hour;
        lh_d    = cd_if.load_ls_hour;
        mm_d    = cd_if.load_ms_min;
        lm_d    = cd_if.load_ls_min;
        rmh_d   = cd_if.load_ms_hour;
        rlh_d   = cd_if.load_ls_hour;
        rmm_d   = cd_if.load_ms_min;
        rlm_d   = cd_if.load_ls_min;
        state_d = S_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (cd_if.stop) begin
      if (state_q == S_RUN) state_d = S_IDLE;
    end else if (cd_if.start) begin
      if ((state_q == S_IDLE) && !cnt_zero) state_d = S_RUN;
    end else if (cd_if.tick && (state_q == S_RUN)) begin
      if (dec_zero) begin
        expired_d = 1'b1;
        if (AUTO_RELOAD && !rld_zero) begin
          mh_d = rmh_q;
          lh_d = rlh_q;
          mm_d = rmm_q;
          lm_d = rlm_q;
        end else begin
          mh_d    = 4'd0;
          lh_d    = 4'd0;
          mm_d    = 4'd0;
          lm_d    = 4'd0;
          state_d = S_DONE;
        end
      end else begin
        mh_d = mh_dec;
        lh_d = lh_dec;
        mm_d = mm_dec;
        lm_d = lm_dec;
      end
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mh_q       <= 4'd0;
      lh_q       <= 4'd0;
      mm_q       <= 4'd0;
      lm_q       <= 4'd0;
      rmh_q      <= 4'd0;
      rlh_q      <= 4'd0;
      rmm_q      <= 4'd0;
      rlm_q      <= 4'd0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mh_q       <= mh_d;
      lh_q       <= lh_d;
      mm_q       <= mm_d;
      lm_q       <= lm_d;
      rmh_q      <= rmh_d;
      rlh_q      <= rlh_d;
      rmm_q      <= rmm_d;
      rlm_q      <= rlm_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign cd_if.ms_hour  = mh_q;
  assign cd_if.ls_hour  = lh_q;
  assign cd_if.ms_min   = mm_q;
  assign cd_if.ls_min   = lm_q;
  assign cd_if.running  = running_q;
  assign cd_if.expired  = expired_q;
  assign cd_if.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench: one timer without and one with auto-reload, hand-derived expectations.
module tb_bcd_countdown;

  logic gclk;
  logic rst;

  bcd_countdown_if if0();
  bcd_countdown_if if1();

  bcd_countdown #(.AUTO_RELOAD(1'b0)) u_dut0 (.clk(gclk), .rst(rst), .cd_if(if0.slave));
  bcd_countdown #(.AUTO_RELOAD(1'b1)) u_dut1 (.clk(gclk), .rst(rst), .cd_if(if1.slave));

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    bit        sel;
    bit [15:0] cnt;
    bit [2:0]  flg;   // {running, expired, load_err}
    string     tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input bit s);
    return s ? {if1.ms_hour, if1.ls_hour, if1.ms_min, if1.ls_min}
             : {if0.ms_hour, if0.ls_hour, if0.ms_min, if0.ls_min};
  endfunction

  function automatic logic [2:0] flg_of(input bit s);
    return s ? {if1.running, if1.expired, if1.load_err}
             : {if0.running, if0.expired, if0.load_err};
  endfunction

  // Pop one expectation per clock edge and compare the addressed DUT.
  always @(posedge gclk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, "/cnt"}, 32'(cnt_of(e.sel)), 32'(e.cnt));
      chk({e.tag, "/flg"}, 32'(flg_of(e.sel)), 32'(e.flg));
    end
  end

  task automatic idle_inputs();
    if0.tick = 0; if0.load = 0; if0.start = 0; if0.stop = 0;
    if0.load_ms_hour = 0; if0.load_ls_hour = 0; if0.load_ms_min = 0; if0.load_ls_min = 0;
    if1.tick = 0; if1.load = 0; if1.start = 0; if1.stop = 0;
    if1.load_ms_hour = 0; if1.load_ls_hour = 0; if1.load_ms_min = 0; if1.load_ls_min = 0;
  endtask

  // ctl = {load, stop, start, tick}
  task automatic step(input bit s, input bit [3:0] ctl, input bit [15:0] ldv,
                      input bit [15:0] ecnt, input bit [2:0] eflg, input string tag);
    exp_t e;
    @(negedge gclk);
    idle_inputs();
    if (s) begin
      {if1.load, if1.stop, if1.start, if1.tick} = ctl;
      {if1.load_ms_hour, if1.load_ls_hour, if1.load_ms_min, if1.load_ls_min} = ldv;
    end else begin
      {if0.load, if0.stop, if0.start, if0.tick} = ctl;
      {if0.load_ms_hour, if0.load_ls_hour, if0.load_ms_min, if0.load_ls_min} = ldv;
    end
    e.sel = s; e.cnt = ecnt; e.flg = eflg; e.tag = tag;
    q.push_back(e);
  endtask

  localparam bit [3:0] LD = 4'b1000, SP = 4'b0100, ST = 4'b0010, TK = 4'b0001, NO = 4'b0000;

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    chk("rst0/cnt", 32'(cnt_of(0)), 32'h0);
    chk("rst0/flg", 32'(flg_of(0)), 32'h0);
    chk("rst1/cnt", 32'(cnt_of(1)), 32'h0);
    @(negedge gclk);
    rst = 1'b0;

    // Countdown to expiry
    step(0, LD, 16'h0002, 16'h0002, 3'b000, "ld0002");
    step(0, ST, 16'h0,    16'h0002, 3'b100, "start");
    step(0, TK, 16'h0,    16'h0001, 3'b100, "tick1");
    step(0, TK, 16'h0,    16'h0000, 3'b010, "tick0");
    step(0, NO, 16'h0,    16'h0000, 3'b000, "expclr");
    step(0, ST, 16'h0,    16'h0000, 3'b000, "done_start");
    step(0, TK, 16'h0,    16'h0000, 3'b000, "done_tick");

    // Borrow ripple
    step(0, LD, 16'h1000, 16'h1000, 3'b000, "ld1000");
    step(0, ST, 16'h0,    16'h1000, 3'b100, "st1000");
    step(0, TK, 16'h0,    16'h0959, 3'b100, "b0959");
    step(0, LD, 16'h2000, 16'h2000, 3'b000, "ld2000");
    step(0, ST, 16'h0,    16'h2000, 3'b100, "st2000");
    step(0, TK, 16'h0,    16'h1959, 3'b100, "b1959");
    step(0, LD, 16'h0100, 16'h0100, 3'b000, "ld0100");
    step(0, ST, 16'h0,    16'h0100, 3'b100, "st0100");
    step(0, TK, 16'h0,    16'h0059, 3'b100, "b0059");

    // Load range checks
    step(0, LD, 16'h2359, 16'h2359, 3'b000, "ld2359");
    step(0, LD, 16'h2400, 16'h2359, 3'b001, "ld2400");
    step(0, NO, 16'h0,    16'h2359, 3'b000, "errclr");
    step(0, LD, 16'h0560, 16'h2359, 3'b001, "ld0560");
    step(0, LD, 16'h300A & 16'hF000, 16'h2359, 3'b001, "ld3000");
    step(0, LD, 16'h001A, 16'h2359, 3'b001, "ld001A");

    // Priority and pause/resume
    step(0, LD, 16'h0005, 16'h0005, 3'b000, "ld0005");
    step(0, ST, 16'h0,    16'h0005, 3'b100, "st0005");
    step(0, SP | TK, 16'h0, 16'h0005, 3'b000, "stop_tick");
    step(0, TK, 16'h0,    16'h0005, 3'b000, "idle_tick");
    step(0, ST, 16'h0,    16'h0005, 3'b100, "resume");
    step(0, TK, 16'h0,    16'h0004, 3'b100, "r0004");
    step(0, SP | ST, 16'h0, 16'h0004, 3'b000, "stop_over_start");
    step(0, ST, 16'h0,    16'h0004, 3'b100, "resume2");
    step(0, LD, 16'h2400, 16'h0004, 3'b101, "badld_run");
    step(0, LD | ST, 16'h0003, 16'h0003, 3'b000, "ld_over_start");

    // Async reset mid-run
    step(0, LD, 16'h1234, 16'h1234, 3'b000, "ld1234");
    step(0, ST, 16'h0,    16'h1234, 3'b100, "st1234");
    step(0, TK, 16'h0,    16'h1233, 3'b100, "b1233");
    @(negedge gclk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("arst/cnt", 32'(cnt_of(0)), 32'h0);
    chk("arst/flg", 32'(flg_of(0)), 32'h0);
    @(negedge gclk);
    rst = 1'b0;
    step(0, ST, 16'h0,    16'h0000, 3'b000, "start_after_rst");

    // Auto-reload instance
    step(1, LD, 16'h0001, 16'h0001, 3'b000, "ar_ld0001");
    step(1, ST, 16'h0,    16'h0001, 3'b100, "ar_start");
    step(1, TK, 16'h0,    16'h0001, 3'b110, "ar_reload1");
    step(1, NO, 16'h0,    16'h0001, 3'b100, "ar_expclr");
    step(1, TK, 16'h0,    16'h0001, 3'b110, "ar_reload2");
    step(1, LD, 16'h0002, 16'h0002, 3'b000, "ar_ld0002");
    step(1, ST, 16'h0,    16'h0002, 3'b100, "ar_st2");
    step(1, TK, 16'h0,    16'h0001, 3'b100, "ar_t1");
    step(1, TK, 16'h0,    16'h0002, 3'b110, "ar_t2");
    step(1, LD, 16'h0000, 16'h0000, 3'b000, "ar_ld0000");
    step(1, ST, 16'h0,    16'h0000, 3'b000, "ar_st_zero");

    @(negedge gclk);
    idle_inputs();
    repeat (2) @(negedge gclk);
    chk("q_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter: AUTO_RELOAD, default 0, meaning when 1 the reload value is restored at expiry and counting continues.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  async active-high reset.
REQ-005 tick  input  1  one-cycle minute strobe, sampled on clk.
REQ-006 load  input  1  one-cycle pulse that captures the load_* digits.
REQ-007 load_ms_hour, load_ls_hour, load_ms_min, load_ls_min  input  4 each  BCD preset value.
REQ-008 start  input  1  one-cycle pulse that begins or resumes counting.
REQ-009 stop  input  1  one-cycle pulse that pauses counting.
REQ-010 ms_hour, ls_hour, ms_min, ls_min  output  4 each  registered current BCD count.
REQ-011 running  output  1  high while in RUN.
REQ-012 expired  output  1  registered one-cycle pulse when the count reaches 00:00.
REQ-013 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-014 The FSM SHALL have three states: IDLE (count held), RUN (count decrements on tick), DONE (count 00:00, held).
REQ-015 Per-cycle input priority SHALL be load > stop > start > tick; lower-priority inputs in the same cycle are ignored.
REQ-016 A load is valid only if ls_min<=9, ms_min<=5, ls_hour<=9, ms_hour<=2, and ms_hour:ls_hour<=23.
REQ-017 A valid load in any state SHALL set the count and an internal reload register to the load digits and enter IDLE at the next edge.
REQ-018 An invalid load SHALL leave the count, reload register and state unchanged and pulse load_err for one cycle.
REQ-019 start in IDLE with a nonzero count SHALL enter RUN; start in IDLE with count 00:00 SHALL be ignored.
REQ-020 start in RUN or DONE SHALL be ignored; only a load exits DONE.
REQ-021 stop in RUN SHALL enter IDLE with the count held; stop in IDLE or DONE SHALL be ignored.
REQ-022 tick outside RUN SHALL have no effect.
REQ-023 tick in RUN SHALL decrement by one minute on that edge (latency 1 cycle): ls_min 0->9 with borrow; ms_min 0->5 with borrow; ls_hour 0->9 with borrow into ms_hour; otherwise the digit decrements by 1.
REQ-024 The borrow SHALL ripple through all digits within the same cycle; 10:00 -> 09:59, 01:00 -> 00:59, 20:00 -> 19:59.
REQ-025 When a decrement yields 00:00 with AUTO_RELOAD=0, the block SHALL enter DONE and assert expired in the cycle after that edge, for one cycle.
REQ-026 When a decrement yields 00:00 with AUTO_RELOAD=1, the count SHALL take the reload value on that same edge, state SHALL remain RUN, and expired SHALL pulse for one cycle.
REQ-027 With AUTO_RELOAD=1 and a reload value of 00:00, the block SHALL enter DONE instead of reloading.
REQ-028 running SHALL equal (state==RUN) and SHALL be registered.
REQ-029 Digits SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-030 rst high SHALL immediately force the state to IDLE, all count digits and the reload register to 0, and running, expired and load_err to 0, independent of clk.
REQ-031 rst asserted mid-RUN SHALL abort counting; after release the block requires load and start to resume.
REQ-032 The first clk edge after rst deasserts SHALL process inputs normally.

Verification
REQ-033 load 00:02, start, two ticks -> count 00:01 then 00:00; expired pulses once; state DONE; running=0.
REQ-034 load 10:00, start, tick -> 09:59; load 20:00, start, tick -> 19:59.
REQ-035 load 23:59 then load 24:00 -> load_err pulses one cycle; count remains 23:59. load 05:60 -> load_err pulses; count is unchanged.
REQ-036 RUN at 00:05: stop and tick in the same cycle -> count remains 00:05 and state is IDLE; a later start resumes counting from 00:05.
REQ-037 AUTO_RELOAD=1, load 00:01, start, tick -> expired pulses; count becomes 00:01; running stays 1.
REQ-038 rst pulse mid-RUN at 12:34 with no clk edge -> all outputs become 0 immediately; start afterwards is ignored because the count is 00:00.
